// File: rtl/axis_bram_dma.sv
// rtl/axis_bram_dma.sv - AXI-Stream to single-port BRAM DMA with concurrent write and read jobs
//
// Purpose: moves an s_axis stream into BRAM (write job) and streams a BRAM
// region out on m_axis (read job). Both jobs share one BRAM port through an
// alternating arbiter; read data returns through a small output FIFO sized so
// that issued reads can never overflow it.
//
// Ports:
//   clk, reset                 sole clock, synchronous active-high reset
//   ctrl_w_start/_index        start pulse and first address of a write job
//   ctrl_r_start/_index/_length start pulse, first address, word count of a read job
//   w_busy, r_busy             job active
//   w_done, r_done             one-cycle completion pulses
//   w_count                    beats written by the last completed write job
//   s_axis_*                   write stream in
//   m_axis_*                   read stream out
//   bram_*                     single BRAM port (bram_clk mirrors clk)
module axis_bram_dma #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctrl_w_start,
  input  logic [ADDR_WIDTH-1:0]   ctrl_w_start_index,
  input  logic                    ctrl_r_start,
  input  logic [ADDR_WIDTH-1:0]   ctrl_r_start_index,
  input  logic [ADDR_WIDTH-1:0]   ctrl_r_length,
  output logic                    w_busy,
  output logic                    r_busy,
  output logic                    w_done,
  output logic                    r_done,
  output logic [ADDR_WIDTH:0]     w_count,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  output logic                    bram_clk,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_din,
  input  logic [DATA_WIDTH-1:0]   bram_dout,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   B_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {W_IDLE, W_RUN} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} r_state_t;

  w_state_t w_state, w_state_nx;
  r_state_t r_state, r_state_nx;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH:0]   w_beats;
  logic [ADDR_WIDTH-1:0] r_addr, r_len, r_issue_left, r_beat;

  logic w_req, r_req, w_gnt, r_gnt, favour_read;
  logic r_credit, m_pop, m_last, push;
  logic [2:0] inflight;

  logic [RD_LATENCY-1:0] rd_pipe;
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr, fifo_cnt;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // ---------------- arbiter ----------------
  assign w_req = (w_state == W_RUN) && s_axis_tvalid;
  assign r_req = (r_state == R_RUN) && r_credit;
  assign r_gnt = r_req && (!w_req || favour_read);
  assign w_gnt = w_req && (!r_req || !favour_read);

  // Priority flips only when both sides actually compete.
  always_ff @(posedge clk) begin
    if (reset) begin
      favour_read <= 1'b1;
    end else if (w_req && r_req) begin
      favour_read <= ~favour_read;
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (ctrl_w_start) w_state_nx = W_RUN;
      W_RUN:   if (w_gnt && s_axis_tlast) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (w_state == W_RUN);
    s_axis_tready = w_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr  <= '0;
      w_beats <= '0;
      w_count <= '0;
      w_done  <= 1'b0;
    end else begin
      w_done <= 1'b0;
      if (w_state == W_IDLE && ctrl_w_start) begin
        w_addr  <= ctrl_w_start_index;
        w_beats <= '0;
      end else if (w_gnt) begin
        w_addr  <= w_addr + A_ONE;
        w_beats <= w_beats + B_ONE;
        if (s_axis_tlast) begin
          w_count <= w_beats + B_ONE;
          w_done  <= 1'b1;
        end
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ctrl_r_start && ctrl_r_length != '0) r_state_nx = R_RUN;
      R_RUN:   if (r_gnt && r_issue_left == A_ONE) r_state_nx = R_DRAIN;
      R_DRAIN: if (m_pop && m_last) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    r_busy = (r_state != R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_len        <= '0;
      r_issue_left <= '0;
      r_beat       <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == R_IDLE && ctrl_r_start) begin
        r_addr       <= ctrl_r_start_index;
        r_len        <= ctrl_r_length;
        r_issue_left <= ctrl_r_length;
        r_beat       <= '0;
        if (ctrl_r_length == '0) r_done <= 1'b1;
      end else begin
        if (r_gnt) begin
          r_addr       <= r_addr + A_ONE;
          r_issue_left <= r_issue_left - A_ONE;
        end
        if (m_pop) begin
          r_beat <= r_beat + A_ONE;
          if (m_last) r_done <= 1'b1;
        end
      end
    end
  end

  // ---------------- read return path ----------------
  // rd_pipe marks which cycles carry valid read data on bram_dout; clearing it
  // on reset drops any data still in flight from an aborted job.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) rd_pipe <= '0;
        else       rd_pipe <= r_gnt;
      end
    end else begin : g_lat2
      always_ff @(posedge clk) begin
        if (reset) rd_pipe <= '0;
        else       rd_pipe <= {rd_pipe[0], r_gnt};
      end
    end
  endgenerate

  assign push = rd_pipe[RD_LATENCY-1];

  // Slots committed after this edge: in flight + stored, less the beat that
  // leaves this cycle. Counting the departing beat keeps 1 beat/cycle possible
  // while still guaranteeing every issued read has a FIFO slot to land in.
  always_comb begin
    inflight = {1'b0, fifo_cnt};
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {2'b00, rd_pipe[i]};
    end
    if (m_pop) inflight = inflight - 3'd1;
  end

  assign r_credit = (inflight < 3'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bram_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)  wr_ptr <= ptr_inc(wr_ptr);
      if (m_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, m_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign m_pop         = m_axis_tvalid && m_axis_tready;
  assign m_last        = (r_beat == r_len - A_ONE);
  assign m_axis_tdata  = fifo_mem[rd_ptr];
  assign m_axis_tstrb  = '1;
  assign m_axis_tlast  = m_axis_tvalid && m_last;

  // ---------------- BRAM port ----------------
  assign bram_clk  = clk;
  assign bram_en   = w_gnt || r_gnt;
  assign bram_we   = w_gnt ? s_axis_tstrb : '0;
  assign bram_addr = w_gnt ? w_addr : (r_gnt ? r_addr : '0);
  assign bram_din  = s_axis_tdata;

endmodule

// File: tb/tb_axis_bram_dma.sv
// tb/tb_axis_bram_dma.sv - scoreboard bench for axis_bram_dma at read latencies 1 and 2
`timescale 1ns/1ps
module tb_axis_bram_dma;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int SW = 8;

  logic clk, reset;
  logic ctrl_w_start, ctrl_r_start;
  logic [AW-1:0] ctrl_w_start_index, ctrl_r_start_index, ctrl_r_length;
  logic s_tvalid, s_tlast, m_tready;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;

  // dut0: RD_LATENCY=1, full traffic. dut1: RD_LATENCY=2, reads only.
  logic w_busy0, r_busy0, w_done0, r_done0, s_tready0, m_tvalid0, m_tlast0, bram_clk0, bram_en0;
  logic [AW:0] w_count0;
  logic [DW-1:0] m_tdata0, bram_din0, bram_dout0;
  logic [SW-1:0] m_tstrb0, bram_we0;
  logic [AW-1:0] bram_addr0;
  logic w_busy1, r_busy1, w_done1, r_done1, s_tready1, m_tvalid1, m_tlast1, bram_clk1, bram_en1;
  logic [AW:0] w_count1;
  logic [DW-1:0] m_tdata1, bram_din1, bram_dout1, dout1a;
  logic [SW-1:0] m_tstrb1, bram_we1;
  logic [AW-1:0] bram_addr1;

  axis_bram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset),
    .ctrl_w_start(ctrl_w_start), .ctrl_w_start_index(ctrl_w_start_index),
    .ctrl_r_start(ctrl_r_start), .ctrl_r_start_index(ctrl_r_start_index), .ctrl_r_length(ctrl_r_length),
    .w_busy(w_busy0), .r_busy(r_busy0), .w_done(w_done0), .r_done(r_done0), .w_count(w_count0),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0), .s_axis_tdata(s_tdata),
    .s_axis_tstrb(s_tstrb), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata0),
    .m_axis_tstrb(m_tstrb0), .m_axis_tlast(m_tlast0),
    .bram_clk(bram_clk0), .bram_addr(bram_addr0), .bram_din(bram_din0), .bram_dout(bram_dout0),
    .bram_en(bram_en0), .bram_we(bram_we0)
  );

  axis_bram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut1 (
    .clk(clk), .reset(reset),
    .ctrl_w_start(1'b0), .ctrl_w_start_index(ctrl_w_start_index),
    .ctrl_r_start(ctrl_r_start), .ctrl_r_start_index(ctrl_r_start_index), .ctrl_r_length(ctrl_r_length),
    .w_busy(w_busy1), .r_busy(r_busy1), .w_done(w_done1), .r_done(r_done1), .w_count(w_count1),
    .s_axis_tvalid(1'b0), .s_axis_tready(s_tready1), .s_axis_tdata(s_tdata),
    .s_axis_tstrb(s_tstrb), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata1),
    .m_axis_tstrb(m_tstrb1), .m_axis_tlast(m_tlast1),
    .bram_clk(bram_clk1), .bram_addr(bram_addr1), .bram_din(bram_din1), .bram_dout(bram_dout1),
    .bram_en(bram_en1), .bram_we(bram_we1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial BRAM content: address embedded twice so any wrong word is visible.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16'hC0DE, 4'h0, a, 20'h00000, a};
  endfunction

  logic [DW-1:0] mem0 [4096];
  logic [DW-1:0] mem1 [4096];

  always @(posedge clk) begin
    if (bram_en0) begin
      for (int b = 0; b < SW; b++)
        if (bram_we0[b]) mem0[bram_addr0][b*8 +: 8] <= bram_din0[b*8 +: 8];
      bram_dout0 <= mem0[bram_addr0];
    end
  end

  always @(posedge clk) begin
    if (bram_en1) begin
      for (int b = 0; b < SW; b++)
        if (bram_we1[b]) mem1[bram_addr1][b*8 +: 8] <= bram_din1[b*8 +: 8];
      dout1a <= mem1[bram_addr1];
    end
    bram_dout1 <= dout1a;
  end

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] we; } wr_t;
  beat_t rq0[$];
  beat_t rq1[$];
  wr_t   wq[$];
  beat_t e0, e1;
  wr_t   ew;
  bit    gnt_log[$];
  bit    log_en;

  int checks, errors;
  int wdone0, rdone0, rdone1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever a DUT presents a transfer.
  always @(negedge clk) begin
    if (w_done0) wdone0++;
    if (r_done0) rdone0++;
    if (r_done1) rdone1++;
    if (m_tvalid0 && m_tready) begin
      if (rq0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_extra_beat: got data %0h with nothing expected", m_tdata0);
      end else begin
        e0 = rq0.pop_front();
        chk("rd0_data", m_tdata0, e0.data);
        chk("rd0_last", m_tlast0, e0.last);
        chk("rd0_strb", m_tstrb0, 8'hFF);
      end
    end
    if (m_tvalid1 && m_tready) begin
      if (rq1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd1_extra_beat: got data %0h with nothing expected", m_tdata1);
      end else begin
        e1 = rq1.pop_front();
        chk("rd1_data", m_tdata1, e1.data);
        chk("rd1_last", m_tlast1, e1.last);
      end
    end
    if (bram_en0 && bram_we0 != '0) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_extra: got write addr %0h with nothing expected", bram_addr0);
      end else begin
        ew = wq.pop_front();
        chk("wr_addr", bram_addr0, ew.addr);
        chk("wr_data", bram_din0, ew.data);
        chk("wr_we", bram_we0, ew.we);
      end
    end
    if (bram_en1 && bram_we1 != '0) begin
      checks++; errors++;
      $display("FAIL wr1_extra: got write addr %0h on read-only instance", bram_addr1);
    end
    if (log_en && bram_en0) gnt_log.push_back(bram_we0 == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] st, input logic last);
    bit ok;
    ok = 0;
    s_tvalid = 1; s_tdata = d; s_tstrb = st; s_tlast = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_tready0;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL w_beat_timeout: got tready=0 expected handshake");
    end
    @(posedge clk);
    #1;
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic send_w(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] st, input logic last);
    wr_t e;
    e.addr = a; e.data = d; e.we = st;
    wq.push_back(e);
    w_beat(d, st, last);
  endtask

  task automatic start_w(input logic [AW-1:0] idx);
    ctrl_w_start = 1; ctrl_w_start_index = idx;
    tick();
    ctrl_w_start = 0;
  endtask

  task automatic expect_rd(input logic [AW-1:0] idx, input int len);
    beat_t b;
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = idx + AW'(i);
      b.data = pat(a);
      b.last = (i == len - 1);
      rq0.push_back(b);
      rq1.push_back(b);
    end
  endtask

  task automatic wait_rd(input bit toggle);
    bit done;
    done = 0;
    m_tready = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (toggle) m_tready = ~m_tready;
      done = (rq0.size() == 0) && (rq1.size() == 0) && !r_busy0 && !r_busy1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_rd_timeout: got %0d/%0d beats pending expected 0", rq0.size(), rq1.size());
    end
    m_tready = 1;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wd, rd0, rd1;
    bit seen;
    checks = 0; errors = 0; wdone0 = 0; rdone0 = 0; rdone1 = 0; log_en = 0;
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = pat(AW'(i));
      mem1[i] = pat(AW'(i));
    end
    reset = 1; ctrl_w_start = 0; ctrl_r_start = 0;
    ctrl_w_start_index = '0; ctrl_r_start_index = '0; ctrl_r_length = '0;
    s_tvalid = 0; s_tdata = '0; s_tstrb = '0; s_tlast = 0; m_tready = 1;
    repeat (3) tick();
    reset = 0;

    // Reset state
    @(negedge clk);
    chk("rst_s_tready", s_tready0, 0);
    chk("rst_m_tvalid", m_tvalid0, 0);
    chk("rst_m_tlast", m_tlast0, 0);
    chk("rst_w_busy", w_busy0, 0);
    chk("rst_r_busy", r_busy0, 0);
    chk("rst_done", {w_done0, r_done0}, 0);
    chk("rst_bram_en", bram_en0, 0);
    chk("rst_bram_we", bram_we0, 0);
    chk("rst_w_count", w_count0, 0);
    chk("rst_m_tvalid1", m_tvalid1, 0);
    tick();

    // Write wrapping the top of the address space
    wd = wdone0;
    start_w(12'hFFE);
    send_w(12'hFFE, 64'h1111_2222_3333_4444, 8'hFF, 0);
    send_w(12'hFFF, 64'h5555_6666_7777_8888, 8'hFF, 0);
    send_w(12'h000, 64'h9999_AAAA_BBBB_CCCC, 8'hFF, 0);
    send_w(12'h001, 64'hDDDD_EEEE_0000_1234, 8'hFF, 1);
    tick(); tick();
    chk("wr_w_count", w_count0, 4);
    chk("wr_w_done_pulses", wdone0 - wd, 1);
    chk("wr_w_busy_end", w_busy0, 0);
    chk("wr_queue_drained", wq.size(), 0);

    // Read of 5 words with tready toggling, both latencies
    rd0 = rdone0; rd1 = rdone1;
    expect_rd(12'h010, 5);
    ctrl_r_start = 1; ctrl_r_start_index = 12'h010; ctrl_r_length = 12'd5;
    tick();
    ctrl_r_start = 0;
    wait_rd(1);
    chk("rd_r_done0", rdone0 - rd0, 1);
    chk("rd_r_done1", rdone1 - rd1, 1);

    // Zero-length read
    rd0 = rdone0; rd1 = rdone1;
    ctrl_r_start = 1; ctrl_r_start_index = 12'h020; ctrl_r_length = 12'd0;
    tick();
    ctrl_r_start = 0;
    @(negedge clk);
    chk("zl_r_done0_next", r_done0, 1);
    chk("zl_r_done1_next", r_done1, 1);
    chk("zl_r_busy0", r_busy0, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | m_tvalid0 | m_tvalid1;
    end
    chk("zl_no_tvalid", seen, 0);
    chk("zl_done_once", (rdone0 - rd0) + (rdone1 - rd1), 2);
    tick();

    // Concurrent 8-beat write and 8-beat read, disjoint regions
    wd = wdone0; rd0 = rdone0;
    expect_rd(12'h040, 8);
    gnt_log.delete();
    log_en = 1;
    m_tready = 1;
    ctrl_w_start = 1; ctrl_w_start_index = 12'h100;
    ctrl_r_start = 1; ctrl_r_start_index = 12'h040; ctrl_r_length = 12'd8;
    tick();
    ctrl_w_start = 0; ctrl_r_start = 0;
    for (int i = 0; i < 8; i++) begin
      ew.addr = 12'h100 + AW'(i);
      ew.data = 64'hBEEF_0000_0000_0000 | 64'(i);
      ew.we = 8'hFF;
      wq.push_back(ew);
    end
    for (int i = 0; i < 8; i++) w_beat(64'hBEEF_0000_0000_0000 | 64'(i), 8'hFF, i == 7);
    wait_rd(0);
    log_en = 0;
    chk("cc_grant_count", gnt_log.size(), 16);
    for (int i = 0; i < 16 && i < gnt_log.size(); i++)
      chk($sformatf("cc_grant_%0d_is_read", i), gnt_log[i], (i % 2) == 0);
    chk("cc_w_done", wdone0 - wd, 1);
    chk("cc_r_done", rdone0 - rd0, 1);
    chk("cc_w_count", w_count0, 8);

    // Abort: reset after 3 of 6 beats
    wd = wdone0;
    start_w(12'h200);
    send_w(12'h200, 64'hA0A0_0000_0000_0000, 8'hFF, 0);
    send_w(12'h201, 64'hA0A0_0000_0000_0001, 8'hFF, 0);
    send_w(12'h202, 64'hA0A0_0000_0000_0002, 8'hFF, 0);
    reset = 1;
    tick();
    reset = 0;
    s_tvalid = 1; s_tdata = 64'hA0A0_0000_0000_0003; s_tstrb = 8'hFF;
    repeat (4) tick();
    s_tvalid = 0;
    @(negedge clk);
    chk("ab_w_busy", w_busy0, 0);
    chk("ab_w_count", w_count0, 0);
    chk("ab_no_w_done", wdone0 - wd, 0);
    chk("ab_queue_drained", wq.size(), 0);
    tick();

    // Start pulse while busy must not move the address
    wd = wdone0;
    start_w(12'h300);
    send_w(12'h300, 64'h0300_0000_0000_0000, 8'h0F, 0);
    send_w(12'h301, 64'h0300_0000_0000_0001, 8'hF0, 0);
    ctrl_w_start = 1; ctrl_w_start_index = 12'h555;
    tick();
    ctrl_w_start = 0;
    send_w(12'h302, 64'h0300_0000_0000_0002, 8'hFF, 0);
    send_w(12'h303, 64'h0300_0000_0000_0003, 8'h81, 1);
    tick(); tick();
    chk("ig_w_count", w_count0, 4);
    chk("ig_w_done", wdone0 - wd, 1);
    chk("ig_queue_drained", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_bram_dma.md
AXIS_BRAM_DMA -- requirements
Module: axis_bram_dma

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, BRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter RD_LATENCY, default 1, BRAM read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL use one clock and a synchronous active-high reset, with ports as follows:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_w_start  in  1  one-cycle pulse that starts a write job.
- ctrl_w_start_index  in  ADDR_WIDTH  first write address.
- ctrl_r_start  in  1  one-cycle pulse that starts a read job.
- ctrl_r_start_index  in  ADDR_WIDTH  first read address.
- ctrl_r_length  in  ADDR_WIDTH  number of words to read.
- w_busy, r_busy  out  1  the job is active.
- w_done, r_done  out  1  one-cycle completion pulse.
- w_count  out  ADDR_WIDTH+1  beats written by the last write job.
- s_axis_tvalid/tready/tdata/tstrb/tlast  in/out/in/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8/1  write stream.
- m_axis_tvalid/tready/tdata/tstrb/tlast  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  read stream.
- bram_clk  out  1  equals clk.
- bram_addr  out  ADDR_WIDTH  BRAM word address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- bram_dout  in  DATA_WIDTH  BRAM read data.
- bram_en  out  1  BRAM access enable.
- bram_we  out  DATA_WIDTH/8  BRAM byte write enables.

Function
REQ-005 SHALL implement the write FSM W_IDLE->W_RUN on ctrl_w_start in W_IDLE, latching the write address and clearing the beat counter; ctrl_w_start SHALL be ignored in W_RUN.
REQ-006 SHALL assert s_axis_tready only in W_RUN when the port is granted to write; tready may depend on tvalid.
REQ-007 SHALL, on each s_axis handshake in the same cycle: drive bram_en=1, bram_we=tstrb, bram_addr=write address, bram_din=tdata; then increment the address modulo 2^ADDR_WIDTH and the beat counter.
REQ-008 SHALL, on a handshake with tlast=1, return to W_IDLE, load w_count with the total beats written, and pulse w_done in the next cycle.
REQ-009 SHALL implement the read FSM R_IDLE->R_RUN->R_DRAIN->R_IDLE; ctrl_r_start in R_IDLE latches address and length; ctrl_r_start outside R_IDLE SHALL be ignored.
REQ-010 SHALL, when ctrl_r_length=0, stay in R_IDLE, emit no beats, and pulse r_done in the next cycle.
REQ-011 SHALL issue a read (bram_en=1, bram_we=0, bram_addr=read address) only when granted and (outstanding reads + output FIFO occupancy) < RD_LATENCY+1; the address increments modulo 2^ADDR_WIDTH.
REQ-012 SHALL capture bram_dout exactly RD_LATENCY cycles after each issue into an output FIFO of depth RD_LATENCY+1; the FIFO SHALL never overflow.
REQ-013 SHALL drive m_axis_tvalid = FIFO non-empty, tdata = FIFO head, tstrb = all ones, and tlast=1 only on beat index length-1.
REQ-014 SHALL move R_RUN->R_DRAIN after the last issue, and R_DRAIN->R_IDLE on the last-beat handshake, with r_done pulsed in the next cycle.
REQ-015 SHALL keep m_axis tdata/tlast stable while tvalid=1 and tready=0.
REQ-016 SHALL arbitrate the single BRAM port:
- write requests when W_RUN and s_axis_tvalid=1; read requests when in R_RUN with credit available.
- a lone requester is granted.
- on conflict the grant alternates, with read favoured first after reset.
REQ-017 SHALL sustain 1 beat/cycle for a lone job when the stream partner never stalls.
REQ-018 SHALL accept write and read start pulses in the same cycle, and run both jobs concurrently.
REQ-019 SHALL drive w_busy = (W_RUN) and r_busy = (R_RUN or R_DRAIN), registered.
REQ-020 SHALL drive bram_en=0 and bram_we=0 in any cycle with no granted access.

Reset
REQ-021 SHALL, on reset:
- set both FSMs to IDLE and empty the FIFO.
- cancel outstanding reads; their returning data SHALL be discarded.
- clear w_count.
- drive all outputs 0 (tready, tvalid, tlast, busy, done, bram_en, bram_we) in the following cycle.
REQ-022 SHALL treat reset mid-job as an abort: no done pulse, and no further BRAM writes from that job.

Verification
REQ-023 SHALL verify a write: ctrl_w_start_index=0xFFE, 4 beats, tstrb=0xFF, tlast on beat 4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; w_count=4; one w_done pulse.
REQ-024 SHALL verify a read: start_index=0x010, length=5, m_axis_tready toggling 1010… -> 5 beats equal to mem[0x010..0x014] in order, tlast only on beat 5, r_done once, no lost or duplicated beat, for both RD_LATENCY=1 and RD_LATENCY=2.
REQ-025 SHALL verify zero length: ctrl_r_length=0 -> m_axis_tvalid stays 0; r_done one cycle after the start.
REQ-026 SHALL verify concurrency: simultaneous write (8 beats, tvalid=1) and read (8 beats, tready=1) -> port grants alternate R,W,R,W…; both jobs complete; read data is the pre-write content when the regions are disjoint.
REQ-027 SHALL verify abort and ignore: reset asserted after 3 of 6 write beats -> no w_done, w_busy=0, w_count=0; a ctrl_w_start while busy -> no effect on the address.
